// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings for the Fast_RV32I hazard controller.
// MemRW codes, forward selects and watchdog FSM states.
package hazard_ctrl_pkg;

  localparam logic [1:0] MEM_NONE  = 2'b00;
  localparam logic [1:0] MEM_STORE = 2'b01;
  localparam logic [1:0] MEM_LOAD  = 2'b10;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  // MEM wins over WB; a load in MEM has no ALU value to give.
  function automatic logic [1:0] fwd_sel(
    input logic mem_hit,
    input logic mem_ld,
    input logic wb_hit
  );
    logic [1:0] s;
    s = FWD_RF;
    if (mem_hit && !mem_ld)
      s = FWD_MEM;
    else if (wb_hit)
      s = FWD_WB;
    return s;
  endfunction

endpackage

// File: rtl/hazard_match.sv
// rd/rs comparator for one source operand against one slot.
// x0 never matches; the operand must actually be read.
module hazard_match #(
  parameter int RA_W = 5
) (
  input  logic [RA_W-1:0] rs_i,
  input  logic            use_i,
  input  logic [RA_W-1:0] rd_i,
  input  logic            regwen_i,
  output logic            hit_o
);

  assign hit_o = use_i & regwen_i
               & (rd_i != '0)
               & (rd_i == rs_i);

endmodule

// File: rtl/hazard_ctrl.sv
// Fast_RV32I pipeline sequencing: stalls, flushes, forwarding
// and a dmem wait-state watchdog that freezes the pipeline.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int RA_W     = 5,
  parameter int WAIT_MAX = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [RA_W-1:0] id_rs1,
  input  logic [RA_W-1:0] id_rs2,
  input  logic            id_use_rs1,
  input  logic            id_use_rs2,
  input  logic [RA_W-1:0] id_rd,
  input  logic            id_regwen,
  input  logic [1:0]      id_memrw,
  input  logic            id_br,
  input  logic            id_flush,
  input  logic            dmem_ready,
  output logic            pc_en,
  output logic            ifid_en,
  output logic            ifid_flush,
  output logic            idex_bubble,
  output logic            exmem_en,
  output logic [1:0]      fwd_a,
  output logic [1:0]      fwd_b,
  output logic            br_fwd_a,
  output logic            br_fwd_b,
  output logic            mem_timeout
);

  localparam logic [7:0] WMAX = 8'(WAIT_MAX);

  logic [RA_W-1:0] ex_rd_q, ex_rs1_q, ex_rs2_q;
  logic            ex_we_q, ex_ld_q, ex_acc_q;
  logic            ex_u1_q, ex_u2_q;
  logic [RA_W-1:0] mem_rd_q;
  logic            mem_we_q, mem_ld_q, mem_acc_q;
  logic [RA_W-1:0] wb_rd_q;
  logic            wb_we_q;

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       tmo_q, tmo_d;

  logic [RA_W-1:0] id_rs [2];
  logic [RA_W-1:0] ex_rs [2];
  logic [1:0] id_use, ex_use;
  logic [1:0] id_ex_hit, id_mem_hit;
  logic [1:0] ex_mem_hit, ex_wb_hit;

  logic freeze, stall, hazard;
  logic id_ld, id_acc;

  assign id_rs[0] = id_rs1;
  assign id_rs[1] = id_rs2;
  assign ex_rs[0] = ex_rs1_q;
  assign ex_rs[1] = ex_rs2_q;
  assign id_use   = {id_use_rs2, id_use_rs1};
  assign ex_use   = {ex_u2_q, ex_u1_q};

  for (genvar i = 0; i < 2; i++) begin : g_cmp
    hazard_match #(.RA_W(RA_W)) u_id_ex (
      .rs_i(id_rs[i]), .use_i(id_use[i]),
      .rd_i(ex_rd_q), .regwen_i(ex_we_q),
      .hit_o(id_ex_hit[i])
    );
    hazard_match #(.RA_W(RA_W)) u_id_mem (
      .rs_i(id_rs[i]), .use_i(id_use[i]),
      .rd_i(mem_rd_q), .regwen_i(mem_we_q),
      .hit_o(id_mem_hit[i])
    );
    hazard_match #(.RA_W(RA_W)) u_ex_mem (
      .rs_i(ex_rs[i]), .use_i(ex_use[i]),
      .rd_i(mem_rd_q), .regwen_i(mem_we_q),
      .hit_o(ex_mem_hit[i])
    );
    hazard_match #(.RA_W(RA_W)) u_ex_wb (
      .rs_i(ex_rs[i]), .use_i(ex_use[i]),
      .rd_i(wb_rd_q), .regwen_i(wb_we_q),
      .hit_o(ex_wb_hit[i])
    );
  end

  assign id_ld  = (id_memrw == MEM_LOAD);
  assign id_acc = (id_memrw == MEM_LOAD)
                | (id_memrw == MEM_STORE);

  assign freeze = mem_acc_q & ~dmem_ready;

  // Load-use, branch on EX producer, branch on MEM load.
  assign hazard = (ex_ld_q & |id_ex_hit)
                | (id_br & |id_ex_hit)
                | (id_br & mem_ld_q & |id_mem_hit);

  assign stall = ~freeze & hazard;

  assign pc_en       = ~freeze & ~stall;
  assign ifid_en     = ~freeze & ~stall;
  assign exmem_en    = ~freeze;
  assign idex_bubble = stall;
  assign ifid_flush  = id_flush & ~freeze
                     & ~stall & ~rst;

  assign fwd_a = fwd_sel(ex_mem_hit[0], mem_ld_q,
                         ex_wb_hit[0]);
  assign fwd_b = fwd_sel(ex_mem_hit[1], mem_ld_q,
                         ex_wb_hit[1]);

  assign br_fwd_a = id_br & id_mem_hit[0] & ~mem_ld_q;
  assign br_fwd_b = id_br & id_mem_hit[1] & ~mem_ld_q;

  assign mem_timeout = tmo_q;

  // Shift the tracking slots unless dmem holds the pipe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_rd_q   <= '0;
      ex_rs1_q  <= '0;
      ex_rs2_q  <= '0;
      ex_we_q   <= 1'b0;
      ex_ld_q   <= 1'b0;
      ex_acc_q  <= 1'b0;
      ex_u1_q   <= 1'b0;
      ex_u2_q   <= 1'b0;
      mem_rd_q  <= '0;
      mem_we_q  <= 1'b0;
      mem_ld_q  <= 1'b0;
      mem_acc_q <= 1'b0;
      wb_rd_q   <= '0;
      wb_we_q   <= 1'b0;
    end else if (!freeze) begin
      wb_rd_q   <= mem_rd_q;
      wb_we_q   <= mem_we_q;
      mem_rd_q  <= ex_rd_q;
      mem_we_q  <= ex_we_q;
      mem_ld_q  <= ex_ld_q;
      mem_acc_q <= ex_acc_q;
      if (stall) begin
        ex_rd_q  <= '0;
        ex_rs1_q <= '0;
        ex_rs2_q <= '0;
        ex_we_q  <= 1'b0;
        ex_ld_q  <= 1'b0;
        ex_acc_q <= 1'b0;
        ex_u1_q  <= 1'b0;
        ex_u2_q  <= 1'b0;
      end else begin
        ex_rd_q  <= id_rd;
        ex_rs1_q <= id_rs1;
        ex_rs2_q <= id_rs2;
        ex_we_q  <= id_regwen;
        ex_ld_q  <= id_ld;
        ex_acc_q <= id_acc;
        ex_u1_q  <= id_use_rs1;
        ex_u2_q  <= id_use_rs2;
      end
    end
  end

  // Watchdog state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
    end
  end

  // Count frozen cycles; the timeout flag is sticky.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    unique case (state_q)
      ST_IDLE: begin
        if (freeze) begin
          state_d = ST_WAIT;
          cnt_d   = 8'd1;
        end
      end
      ST_WAIT: begin
        if (!freeze) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q < WMAX) begin
          cnt_d = cnt_q + 8'd1;
        end
      end
    endcase
    if (freeze && cnt_d == WMAX)
      tmo_d = 1'b1;
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: instruction-level pipeline model
// checked every cycle, plus directed literal expectations.
module tb_hazard_ctrl;

  localparam int RA_W     = 5;
  localparam int WAIT_MAX = 15;
  localparam logic [1:0] NO = 2'b00;
  localparam logic [1:0] ST = 2'b01;
  localparam logic [1:0] LD = 2'b10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic id_use_rs1 = 0, id_use_rs2 = 0, id_regwen = 0;
  logic [1:0] id_memrw = '0;
  logic id_br = 0, id_flush = 0, dmem_ready = 1;
  logic pc_en, ifid_en, ifid_flush, idex_bubble, exmem_en;
  logic [1:0] fwd_a, fwd_b;
  logic br_fwd_a, br_fwd_b, mem_timeout;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.RA_W(RA_W), .WAIT_MAX(WAIT_MAX)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_rd(id_rd), .id_regwen(id_regwen),
    .id_memrw(id_memrw), .id_br(id_br),
    .id_flush(id_flush), .dmem_ready(dmem_ready),
    .pc_en(pc_en), .ifid_en(ifid_en),
    .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
    .exmem_en(exmem_en), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .br_fwd_a(br_fwd_a), .br_fwd_b(br_fwd_b),
    .mem_timeout(mem_timeout)
  );

  task automatic chk(input string nm, input int act,
                     input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d @%0t",
               nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [4:0] rd;
    logic       we;
    logic       ld;
    logic       acc;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
  } ins_t;

  ins_t m_ex = '0, m_mem = '0, m_wb = '0;
  int   run = 0;
  bit   tmo = 0;

  function automatic bit writes(ins_t s, logic [4:0] r,
                                logic u);
    return u && r != 0 && s.we && s.rd == r;
  endfunction

  function automatic ins_t id_ins();
    ins_t n;
    n.rd  = id_rd;
    n.we  = id_regwen;
    n.ld  = (id_memrw == LD);
    n.acc = (id_memrw != NO);
    n.rs1 = id_rs1;
    n.rs2 = id_rs2;
    n.u1  = id_use_rs1;
    n.u2  = id_use_rs2;
    return n;
  endfunction

  function automatic bit frz();
    return m_mem.acc && !dmem_ready;
  endfunction

  function automatic bit haz();
    bit on_ex, on_mem;
    on_ex  = writes(m_ex, id_rs1, id_use_rs1)
          || writes(m_ex, id_rs2, id_use_rs2);
    on_mem = writes(m_mem, id_rs1, id_use_rs1)
          || writes(m_mem, id_rs2, id_use_rs2);
    if (m_ex.ld && on_ex) return 1;
    if (id_br && on_ex) return 1;
    if (id_br && m_mem.ld && on_mem) return 1;
    return 0;
  endfunction

  // Newest older producer supplies the EX operand.
  function automatic int src(logic [4:0] r, logic u);
    if (writes(m_mem, r, u) && !m_mem.ld) return 1;
    if (writes(m_wb, r, u)) return 2;
    return 0;
  endfunction

  always @(posedge clk or posedge rst) begin : mdl
    ins_t nx;
    bit   h;
    if (rst) begin
      m_ex = '0; m_mem = '0; m_wb = '0;
      run = 0; tmo = 0;
    end else if (frz()) begin
      if (run < WAIT_MAX) run++;
      if (run == WAIT_MAX) tmo = 1;
    end else begin
      h  = haz();
      nx = id_ins();
      run   = 0;
      m_wb  = m_mem;
      m_mem = m_ex;
      m_ex  = h ? '0 : nx;
    end
  end

  always @(negedge clk) begin : cmp
    bit f, s;
    f = frz();
    s = !f && haz();
    chk("pc_en", pc_en, !(f || s));
    chk("ifid_en", ifid_en, !(f || s));
    chk("exmem_en", exmem_en, !f);
    chk("idex_bubble", idex_bubble, s);
    chk("ifid_flush", ifid_flush,
        id_flush && !f && !s && !rst);
    chk("fwd_a", fwd_a, src(m_ex.rs1, m_ex.u1));
    chk("fwd_b", fwd_b, src(m_ex.rs2, m_ex.u2));
    chk("br_fwd_a", br_fwd_a, id_br
        && writes(m_mem, id_rs1, id_use_rs1) && !m_mem.ld);
    chk("br_fwd_b", br_fwd_b, id_br
        && writes(m_mem, id_rs2, id_use_rs2) && !m_mem.ld);
    chk("mem_timeout", mem_timeout, tmo);
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic id(input logic [4:0] rs1, rs2,
                    input logic u1, u2,
                    input logic [4:0] rd,
                    input logic we,
                    input logic [1:0] mrw,
                    input logic br, fl);
    id_rs1 = rs1; id_rs2 = rs2;
    id_use_rs1 = u1; id_use_rs2 = u2;
    id_rd = rd; id_regwen = we;
    id_memrw = mrw; id_br = br; id_flush = fl;
  endtask

  task automatic nop();
    id(0, 0, 0, 0, 0, 0, NO, 0, 0);
  endtask

  task automatic drain();
    nop();
    repeat (3) cyc();
  endtask

  initial begin
    #2;
    chk("rst_pc_en", pc_en, 1);
    chk("rst_ifid_en", ifid_en, 1);
    chk("rst_exmem_en", exmem_en, 1);
    chk("rst_bubble", idex_bubble, 0);
    chk("rst_tmo", mem_timeout, 0);
    cyc(); cyc();
    rst = 0;

    // lw x5 ; add x6,x5,x1
    cyc(); id(2, 0, 1, 0, 5, 1, LD, 0, 0);
    cyc(); id(5, 1, 1, 1, 6, 1, NO, 0, 0);
    #2 chk("lu_pc_en", pc_en, 0);
    chk("lu_bubble", idex_bubble, 1);
    cyc(); #2 chk("lu_resume", pc_en, 1);
    cyc(); nop(); #2 chk("lu_fwd_a", fwd_a, 2);
    chk("lu_fwd_b", fwd_b, 0);
    drain();

    // add x5 ; sub x7,x5,x5
    cyc(); id(1, 2, 1, 1, 5, 1, NO, 0, 0);
    cyc(); id(5, 5, 1, 1, 7, 1, NO, 0, 0);
    #2 chk("alu_nostall", pc_en, 1);
    cyc(); nop(); #2 chk("alu_fwd_a", fwd_a, 1);
    chk("alu_fwd_b", fwd_b, 1);
    drain();

    // lw x3 ; beq x3,x0 with flush
    cyc(); id(1, 0, 1, 0, 3, 1, LD, 0, 0);
    cyc(); id(3, 0, 1, 1, 0, 0, NO, 1, 1);
    #2 chk("bld_flush1", ifid_flush, 0);
    chk("bld_pc1", pc_en, 0);
    cyc(); #2 chk("bld_flush2", ifid_flush, 0);
    chk("bld_bub2", idex_bubble, 1);
    cyc(); #2 chk("bld_flush3", ifid_flush, 1);
    chk("bld_pc3", pc_en, 1);
    chk("bld_brfwd", br_fwd_a, 0);
    drain();

    // add x5 ; beq x5,x6
    cyc(); id(1, 2, 1, 1, 5, 1, NO, 0, 0);
    cyc(); id(5, 6, 1, 1, 0, 0, NO, 1, 0);
    #2 chk("balu_pc1", pc_en, 0);
    cyc(); #2 chk("balu_pc2", pc_en, 1);
    chk("balu_brfwd_a", br_fwd_a, 1);
    chk("balu_brfwd_b", br_fwd_b, 0);
    drain();

    // add x0,x1,x2 ; add x4,x0,x0
    cyc(); id(1, 2, 1, 1, 0, 1, NO, 0, 0);
    cyc(); id(0, 0, 1, 1, 4, 1, NO, 0, 0);
    #2 chk("x0_nostall", pc_en, 1);
    cyc(); nop(); #2 chk("x0_fwd_a", fwd_a, 0);
    chk("x0_fwd_b", fwd_b, 0);
    drain();

    // sw with 3 wait states
    cyc(); id(1, 2, 1, 1, 0, 0, ST, 0, 0);
    cyc(); nop();
    cyc(); dmem_ready = 0; #2 chk("sw_frz1", exmem_en, 0);
    cyc(); #2 chk("sw_frz2", exmem_en, 0);
    cyc(); #2 chk("sw_frz3", exmem_en, 0);
    cyc(); dmem_ready = 1; #2 chk("sw_go", exmem_en, 1);
    chk("sw_tmo", mem_timeout, 0);
    drain();

    // watchdog: 15 wait states
    cyc(); id(1, 2, 1, 1, 0, 0, ST, 0, 0);
    cyc(); nop();
    cyc(); dmem_ready = 0;
    repeat (13) cyc();
    cyc(); #2 chk("wd_14", mem_timeout, 0);
    cyc(); dmem_ready = 1; #2 chk("wd_15", mem_timeout, 1);
    cyc(); #2 chk("wd_sticky", mem_timeout, 1);
    drain();

    // reset mid-wait
    cyc(); id(1, 2, 1, 1, 0, 0, ST, 0, 0);
    cyc(); nop();
    cyc(); dmem_ready = 0;
    cyc(); #2 rst = 1;
    #1 chk("rw_pc_en", pc_en, 1);
    chk("rw_exmem_en", exmem_en, 1);
    chk("rw_ifid_en", ifid_en, 1);
    chk("rw_tmo", mem_timeout, 0);
    dmem_ready = 1;
    cyc(); cyc(); rst = 0;

    // reset mid-stall
    cyc(); id(2, 0, 1, 0, 5, 1, LD, 0, 0);
    cyc(); id(5, 1, 1, 1, 6, 1, NO, 0, 0);
    #2 chk("rs_pc0", pc_en, 0);
    rst = 1;
    #1 chk("rs_pc_en", pc_en, 1);
    chk("rs_bubble", idex_bubble, 0);
    nop();
    cyc(); cyc(); rst = 0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
